// File: rtl/lpm_or_serial_ctl.sv
// Serial OR reduction: ORs up to lpm_size lpm_width-bit words arriving on a
// valid/ready stream into one result, reusing a single OR stage over time.
module lpm_or_serial_ctl #(
    parameter int lpm_width  = 1,
    parameter int lpm_size   = 1,
    parameter int lpm_widthc = 8,
    parameter     lpm_type   = "lpm_or_serial_ctl",
    parameter     lpm_hint   = "UNUSED"
) (
    input  logic                  clock,
    input  logic                  sclr,
    input  logic                  start,
    input  logic [lpm_widthc-1:0] count,
    output logic                  busy,
    input  logic [lpm_width-1:0]  data,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [lpm_widthc-1:0] word_index,
    output logic [lpm_width-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [lpm_widthc-1:0] size_c = lpm_widthc'(lpm_size);
    localparam logic [lpm_widthc-1:0] one_c  = lpm_widthc'(1);

    state_t                  state_q, state_d;
    logic [lpm_width-1:0]    acc_q, acc_d;
    logic [lpm_width-1:0]    result_q, result_d;
    logic [lpm_widthc-1:0]   idx_q, idx_d;
    logic [lpm_widthc-1:0]   rem_q, rem_d;
    logic [lpm_widthc-1:0]   count_clamped;

    assign count_clamped = (count > size_c) ? size_c : count;

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
        end
    end

    // Both streams transfer on a clock edge where valid and ready are high
    // together; ready is a pure function of state and never looks at valid.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        result_d     = result_q;
        idx_d        = idx_q;
        rem_d        = rem_q;
        busy         = 1'b0;
        data_ready   = 1'b0;
        result_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    idx_d    = '0;
                    result_d = '0;
                    // Zero words is the OR identity: go straight to DONE with 0.
                    if (count == '0) begin
                        state_d = DONE;
                    end else begin
                        rem_d   = count_clamped;
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                busy       = 1'b1;
                data_ready = 1'b1;
                if (data_valid) begin
                    acc_d = acc_q | data;
                    idx_d = idx_q + one_c;
                    rem_d = rem_q - one_c;
                    if (rem_q == one_c) begin
                        result_d = acc_q | data;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign result     = result_q;
    assign word_index = idx_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_lpm_or_serial_ctl.sv
// Bench for lpm_or_serial_ctl: directed steps plus randomized jobs, each job's
// expected result computed as the plain OR of the words the bench offers.
module tb_lpm_or_serial_ctl;

    localparam int W    = 8;
    localparam int SIZE = 4;
    localparam int C    = 8;

    logic         clock;
    logic         sclr;
    logic         start;
    logic [C-1:0] count;
    logic         busy;
    logic [W-1:0] data;
    logic         data_valid;
    logic         data_ready;
    logic [C-1:0] word_index;
    logic [W-1:0] result;
    logic         result_valid;
    logic         result_ready;
    logic [1:0]   fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] word_q[$];

    lpm_or_serial_ctl #(
        .lpm_width (W),
        .lpm_size  (SIZE),
        .lpm_widthc(C)
    ) dut (
        .clock       (clock),
        .sclr        (sclr),
        .start       (start),
        .count       (count),
        .busy        (busy),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .word_index  (word_index),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .fsm_state   (fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".data_ready"}, 32'(data_ready), 0);
        check({tag, ".result_valid"}, 32'(result_valid), 0);
    endtask

    task automatic check_done(input string tag, input logic [W-1:0] exp_res, input int exp_n);
        check({tag, ".result_valid"}, 32'(result_valid), 1);
        check({tag, ".busy"}, 32'(busy), 1);
        check({tag, ".data_ready"}, 32'(data_ready), 0);
        check({tag, ".result"}, 32'(result), 32'(exp_res));
        check({tag, ".word_index"}, 32'(word_index), 32'(exp_n));
    endtask

    // Runs one job from IDLE using the words in word_q; the reference is the
    // OR of the first min(cnt, SIZE) words.
    task automatic run_job(input string tag, input int cnt, input int max_gap, input int hold);
        int n;
        logic [W-1:0] exp_res;
        n = (cnt > SIZE) ? SIZE : cnt;
        exp_res = '0;
        start = 1'b1;
        count = C'(cnt);
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                data_valid = 1'b0;
                data = W'($urandom);
                check({tag, ".stall_ready"}, 32'(data_ready), 1);
                tick();
            end
            data_valid = 1'b1;
            data = word_q[i];
            exp_res |= word_q[i];
            tick();
        end
        data_valid = 1'b0;
        check_done(tag, exp_res, n);
        for (int h = 0; h < hold; h++) begin
            result_ready = 1'b0;
            data_valid = 1'b1;
            data = W'($urandom);
            start = 1'b1;
            tick();
            check({tag, ".hold_result"}, 32'(result), 32'(exp_res));
            check({tag, ".hold_valid"}, 32'(result_valid), 1);
        end
        data_valid = 1'b0;
        start = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_idle({tag, ".after_hs"});
        check({tag, ".result_kept"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        sclr = 1'b1;
        start = 1'b0;
        count = '0;
        data = '0;
        data_valid = 1'b0;
        result_ready = 1'b0;

        // Reset with random inputs for two cycles.
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom_range(0, 1));
            count = C'($urandom_range(0, 255));
            data = W'($urandom);
            data_valid = 1'($urandom_range(0, 1));
            result_ready = 1'($urandom_range(0, 1));
            tick();
            check_idle("reset");
            check("reset.result", 32'(result), 0);
            check("reset.word_index", 32'(word_index), 0);
        end

        // Reset wins over start in the same cycle.
        start = 1'b1;
        count = 3;
        tick();
        check_idle("reset_vs_start");
        check("reset_vs_start.state", 32'(fsm_state), 0);
        sclr = 1'b0;
        start = 1'b0;
        data_valid = 1'b0;
        result_ready = 1'b0;
        tick();
        check_idle("idle");

        // Basic reduce.
        word_q = '{8'h01, 8'h10, 8'h00, 8'h80};
        run_job("basic", 4, 0, 0);
        tick();

        // Stall then backpressure.
        word_q = '{8'h03, 8'h0C, 8'h30};
        start = 1'b1;
        count = 3;
        tick();
        start = 1'b0;
        data_valid = 1'b1;
        data = word_q[0];
        tick();
        for (int g = 0; g < 3; g++) begin
            data_valid = 1'b0;
            data = 8'hC0;
            tick();
            check("stall.busy", 32'(busy), 1);
            check("stall.word_index", 32'(word_index), 1);
        end
        for (int i = 1; i < 3; i++) begin
            data_valid = 1'b1;
            data = word_q[i];
            tick();
        end
        data_valid = 1'b0;
        check_done("stall", 8'h3F, 3);
        for (int h = 0; h < 4; h++) begin
            tick();
            check("backpressure.result", 32'(result), 32'h3F);
            check("backpressure.data_ready", 32'(data_ready), 0);
            check("backpressure.result_valid", 32'(result_valid), 1);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_idle("backpressure.release");
        tick();

        // Boundary counts.
        word_q = {};
        run_job("count0", 0, 0, 1);
        word_q = '{8'h11, 8'h22, 8'h44, 8'h08};
        run_job("count9", 9, 0, 2);
        word_q = '{8'hA5};
        run_job("count1", 1, 0, 0);
        tick();

        // Abort mid-accumulation.
        start = 1'b1;
        count = 4;
        tick();
        start = 1'b0;
        data_valid = 1'b1;
        data = 8'hFF;
        tick();
        data = 8'h01;
        tick();
        data_valid = 1'b0;
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check_idle("abort");
        check("abort.result", 32'(result), 0);
        check("abort.word_index", 32'(word_index), 0);
        word_q = '{8'h02};
        run_job("after_abort", 1, 0, 0);

        // Back-to-back with start held high throughout.
        start = 1'b1;
        count = 2;
        tick();
        data_valid = 1'b1;
        data = 8'h0C;
        tick();
        data = 8'h03;
        tick();
        data_valid = 1'b0;
        check_done("b2b_first", 8'h0F, 2);
        tick();
        check("b2b.start_in_done", 32'(result_valid), 1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_idle("b2b.bubble");
        tick();
        check("b2b.second_busy", 32'(busy), 1);
        check("b2b.second_ready", 32'(data_ready), 1);
        start = 1'b0;
        data_valid = 1'b1;
        data = 8'h30;
        tick();
        data = 8'hC0;
        tick();
        data_valid = 1'b0;
        check_done("b2b_second", 8'hF0, 2);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_idle("b2b.end");

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            int cnt;
            cnt = int'($urandom_range(0, 6));
            word_q = {};
            for (int i = 0; i < SIZE; i++) word_q.push_back(W'($urandom));
            run_job("random", cnt, 2, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
